// File: rtl/piece_motion_ctrl_if.sv
// Command channel from game logic to one piece's motion controller.
// Valid/ready handshake carrying a move destination or a capture request.
interface piece_motion_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_kill;
  logic [2:0] cmd_file;
  logic [2:0] cmd_rank;

  modport master (
    output cmd_valid,
    output cmd_kill,
    output cmd_file,
    output cmd_rank,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_kill,
    input  cmd_file,
    input  cmd_rank,
    output cmd_ready
  );
endinterface

// File: rtl/piece_motion_ctrl.sv
// Slides one piece's sprite square-to-square, stepping offsets only on frame ticks.
// Offsets are board-relative pixels; capture makes the piece permanently hidden until reset.
module piece_motion_ctrl #(
  parameter int unsigned STEP_PX   = 4,
  parameter int unsigned INIT_FILE = 0,
  parameter int unsigned INIT_RANK = 0,
  parameter int unsigned SQUARE_PX = 60
) (
  input  logic                 i_vga_clk,
  input  logic                 i_reset,
  input  logic                 i_frame_tick,
  piece_motion_ctrl_if.slave   cmd,
  output logic [9:0]           o_offset_x,
  output logic [9:0]           o_offset_y,
  output logic                 o_captured,
  output logic                 o_moving,
  output logic                 o_done
);

  typedef enum logic [1:0] {StIdle, StSlide, StArrive, StDead} state_e;

  localparam logic [9:0]        InitX = 10'(INIT_FILE * SQUARE_PX);
  localparam logic [9:0]        InitY = 10'(INIT_RANK * SQUARE_PX);
  localparam logic signed [10:0] Step = 11'(STEP_PX);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [9:0] r_cur_x, r_cur_y, r_tgt_x, r_tgt_y;
  logic       r_captured;
  logic [9:0] w_cmd_x, w_cmd_y, w_nx_x, w_nx_y;
  logic       w_accept, w_same, w_last_step;

  // One axis step: snap to target when within a step, else move one step toward it.
  function automatic logic [9:0] axis_step(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (d <= Step && d >= -Step) return tgt;
    else if (d > 0)              return cur + Step[9:0];
    else                         return cur - Step[9:0];
  endfunction

  assign w_cmd_x     = 10'(32'(cmd.cmd_file) * SQUARE_PX);
  assign w_cmd_y     = 10'(32'(cmd.cmd_rank) * SQUARE_PX);
  assign w_accept    = (r_state == StIdle) && cmd.cmd_valid;
  assign w_same      = (w_cmd_x == r_cur_x) && (w_cmd_y == r_cur_y);
  assign w_nx_x      = axis_step(r_cur_x, r_tgt_x);
  assign w_nx_y      = axis_step(r_cur_y, r_tgt_y);
  assign w_last_step = (w_nx_x == r_tgt_x) && (w_nx_y == r_tgt_y);

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_nxt = (cmd.cmd_kill || w_same) ? StArrive : StSlide;
      end
      StSlide: begin
        if (i_frame_tick && w_last_step) w_state_nxt = StArrive;
      end
      StArrive: w_state_nxt = r_captured ? StDead : StIdle;
      StDead:   w_state_nxt = StDead;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (r_state == StIdle);
    o_moving      = (r_state == StSlide);
    o_done        = (r_state == StArrive);
  end

  // Accept-cycle ticks are ignored because stepping only happens in StSlide.
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_cur_x    <= InitX;
      r_cur_y    <= InitY;
      r_tgt_x    <= InitX;
      r_tgt_y    <= InitY;
      r_captured <= 1'b0;
    end else begin
      if (w_accept && cmd.cmd_kill) r_captured <= 1'b1;
      if (w_accept && !cmd.cmd_kill) begin
        r_tgt_x <= w_cmd_x;
        r_tgt_y <= w_cmd_y;
      end
      if (r_state == StSlide && i_frame_tick) begin
        r_cur_x <= w_nx_x;
        r_cur_y <= w_nx_y;
      end
    end
  end

  assign o_offset_x = r_cur_x;
  assign o_offset_y = r_cur_y;
  assign o_captured = r_captured;

endmodule
